alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM encoding, default latency.
package alu_pkg;

  localparam int unsigned LAT_DEF = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_NOR  = 4'd10,
    OP_NAND = 4'd11,
    OP_XOR  = 4'd12,
    OP_XNOR = 4'd13,
    OP_SLT  = 4'd14,
    OP_SEQ  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Single-outstanding issue controller: latches a command onto a fixed-latency ALU,
// waits LAT cycles, then presents the captured result with valid/ready.
//   state | meaning
//   IDLE  | ready for a command
//   WAIT  | operands held on the ALU, counting down to a settled result
//   RESP  | response presented until the downstream takes it
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned LAT   = LAT_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             c,
  input  logic             r,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [3:0]       cmd_tag,
  output logic [3:0]       alu_s,
  output logic [15:0]      alu_x,
  output logic [15:0]      alu_y,
  input  logic [31:0]      alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [3:0]       rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int unsigned WC_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [3:0]       alu_s_q, alu_s_d;
  logic [15:0]      alu_x_q, alu_x_d;
  logic [15:0]      alu_y_q, alu_y_d;
  logic [3:0]       tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic             accept;
  logic             div0;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign div0      = (cmd_op == OP_DIV) && (cmd_b == 16'd0);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    alu_s_d  = alu_s_q;
    alu_x_d  = alu_x_q;
    alu_y_d  = alu_y_q;
    tag_d    = tag_q;
    data_d   = data_q;
    err_d    = err_q;
    op_cnt_d = op_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tag_d = cmd_tag;
          // Divide by zero never reaches the ALU; operands stay as they were.
          if (div0) begin
            data_d  = 32'd0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            alu_s_d = cmd_op;
            alu_x_d = cmd_a;
            alu_y_d = cmd_b;
            wcnt_d  = WC_W'(LAT);
            err_d   = 1'b0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          data_d  = alu_z;
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - WC_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_cnt_d = op_cnt_q + CNT_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      alu_s_q  <= '0;
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      tag_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      alu_s_q  <= alu_s_d;
      alu_x_q  <= alu_x_d;
      alu_y_q  <= alu_y_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      err_q    <= err_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign alu_s     = alu_s_q;
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized commands
// against a behavioural ALU and transaction-level expectations.
module tb_alu_issue_ctrl;

  localparam int unsigned LAT   = 2;
  localparam int unsigned CNT_W = 8;

  logic             c = 1'b0;
  logic             r = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = '0;
  logic [15:0]      cmd_a = '0;
  logic [15:0]      cmd_b = '0;
  logic [3:0]       cmd_tag = '0;
  logic [3:0]       alu_s;
  logic [15:0]      alu_x;
  logic [15:0]      alu_y;
  logic [31:0]      alu_z;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [3:0]       rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_cnt;

  always #5 c = ~c;

  alu_issue_ctrl #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .c(c), .r(r),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy), .op_cnt(op_cnt)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned exp_cnt = 0;
  logic [3:0]  exp_s = '0;
  logic [15:0] exp_x = '0;
  logic [15:0] exp_y = '0;

  function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [15:0] x,
                                          input logic [15:0] y);
    logic [31:0] res;
    logic [31:0] d;
    logic [31:0] rot;
    logic [4:0]  n;
    n = {1'b0, y[3:0]};
    d = {x, x};
    case (s)
      4'd0:  res = {16'h0, x} + {16'h0, y};
      4'd1:  res = {16'h0, x} - {16'h0, y};
      4'd2:  res = {16'h0, x} * {16'h0, y};
      4'd3:  res = (y == 16'd0) ? 32'd0 : {16'h0, x / y};
      4'd4:  res = {16'h0, x} << n;
      4'd5:  res = {16'h0, x >> n};
      4'd6:  begin rot = d >> (5'd16 - n); res = {16'h0, rot[15:0]}; end
      4'd7:  begin rot = d >> n; res = {16'h0, rot[15:0]}; end
      4'd8:  res = {16'h0, x & y};
      4'd9:  res = {16'h0, x | y};
      4'd10: res = {16'h0, ~(x | y)};
      4'd11: res = {16'h0, ~(x & y)};
      4'd12: res = {16'h0, x ^ y};
      4'd13: res = {16'h0, ~(x ^ y)};
      4'd14: res = {31'h0, $signed(x) < $signed(y)};
      default: res = {31'h0, x == y};
    endcase
    return res;
  endfunction

  // Behavioural ALU seen by the DUT.
  assign alu_z = ref_alu(alu_s, alu_x, alu_y);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic scramble();
    cmd_valid = 1'($urandom);
    cmd_op    = 4'($urandom);
    cmd_a     = 16'($urandom);
    cmd_b     = 16'($urandom);
    cmd_tag   = 4'($urandom);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data, 32'd0);
    chk({tag, "_rsp_tag"},   32'(rsp_tag), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_alu_s"},     32'(alu_s), 32'd0);
    chk({tag, "_alu_x"},     32'(alu_x), 32'd0);
    chk({tag, "_alu_y"},     32'(alu_y), 32'd0);
    chk({tag, "_op_cnt"},    32'(op_cnt), 32'd0);
  endtask

  // Present a command, check the accept edge and the response arrival time.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    tick();
    scramble();
    if (op == 4'd3 && b == 16'd0) begin
      chk("dz_valid", 32'(rsp_valid), 32'd1);
      chk("dz_err",   32'(rsp_err), 32'd1);
      chk("dz_data",  rsp_data, 32'd0);
      chk("dz_tag",   32'(rsp_tag), 32'(tag));
      chk("dz_alu_s", 32'(alu_s), 32'(exp_s));
      chk("dz_alu_x", 32'(alu_x), 32'(exp_x));
      chk("dz_alu_y", 32'(alu_y), 32'(exp_y));
    end else begin
      exp_s = op; exp_x = a; exp_y = b;
      chk("acc_alu_s", 32'(alu_s), 32'(exp_s));
      chk("acc_alu_x", 32'(alu_x), 32'(exp_x));
      chk("acc_alu_y", 32'(alu_y), 32'(exp_y));
      chk("acc_busy",  32'(busy), 32'd1);
      for (int i = 0; i <= int'(LAT); i++) begin
        chk("early_valid", 32'(rsp_valid), 32'd0);
        chk("wait_ready",  32'(cmd_ready), 32'd0);
        scramble();
        tick();
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_data",  rsp_data, ref_alu(op, a, b));
      chk("rsp_tag",   32'(rsp_tag), 32'(tag));
      chk("rsp_err",   32'(rsp_err), 32'd0);
    end
  endtask

  // Hold the response for some cycles, then take it.
  task automatic finish(input int hold, input logic [31:0] d, input logic [3:0] tag,
                        input logic err);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      scramble();
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data",  rsp_data, d);
      chk("hold_tag",   32'(rsp_tag), 32'(tag));
      chk("hold_err",   32'(rsp_err), 32'(err));
      chk("hold_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    scramble();
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk("done_op_cnt", 32'(op_cnt), 32'(exp_cnt));
    chk("done_valid",  32'(rsp_valid), 32'd0);
    chk("done_ready",  32'(cmd_ready), 32'd1);
    chk("done_alu_s",  32'(alu_s), 32'(exp_s));
    chk("done_alu_x",  32'(alu_x), 32'(exp_x));
  endtask

  task automatic rand_op(input int hold);
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  tag;
    logic        dz;
    op  = 4'($urandom);
    a   = 16'($urandom);
    b   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    tag = 4'($urandom);
    dz  = (op == 4'd3) && (b == 16'd0);
    issue(op, a, b, tag);
    finish(hold, dz ? 32'd0 : ref_alu(op, a, b), tag, dz);
  endtask

  task automatic back_to_back();
    logic [35:0] exp_q[$];
    logic [35:0] front;
    int cyc, n_acc, n_rsp, last_acc;
    logic acc;
    cyc = 0; n_acc = 0; n_rsp = 0; last_acc = -1;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    cmd_op = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom) | 16'h1;
    cmd_tag = 4'(n_acc + 1);
    while (n_rsp < 4 && cyc < 100) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b_extra_rsp", 32'd1, 32'd0);
        end else begin
          front = exp_q.pop_front();
          chk("b2b_tag",  32'(rsp_tag), 32'(front[35:32]));
          chk("b2b_data", rsp_data, front[31:0]);
          chk("b2b_err",  32'(rsp_err), 32'd0);
        end
        n_rsp++;
      end
      acc = cmd_valid && cmd_ready;
      if (acc) begin
        exp_q.push_back({cmd_tag, ref_alu(cmd_op, cmd_a, cmd_b)});
        exp_s = cmd_op; exp_x = cmd_a; exp_y = cmd_b;
        if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'(LAT + 3));
        last_acc = cyc;
        n_acc++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (n_acc < 4) begin
          cmd_op = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom) | 16'h1;
          cmd_tag = 4'(n_acc + 1);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 32'd4);
    chk("b2b_rsps",    32'(n_rsp), 32'd4);
    exp_cnt = (exp_cnt + 4) % (1 << CNT_W);
    chk("b2b_op_cnt",  32'(op_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int guard;
    tick();
    tick();
    r = 1'b0;
    chk_reset_vals("reset");

    // 3 + 5, tag 2
    issue(4'd0, 16'd3, 16'd5, 4'd2);
    chk("add_data_const", rsp_data, 32'd8);
    finish(0, 32'd8, 4'd2, 1'b0);
    chk("add_op_cnt", 32'(op_cnt), 32'd1);

    // 100 / 0, tag 7
    issue(4'd3, 16'd100, 16'd0, 4'd7);
    finish(0, 32'd0, 4'd7, 1'b1);

    // 0xFFFF * 0xFFFF held for 5 cycles
    issue(4'd2, 16'hFFFF, 16'hFFFF, 4'd9);
    finish(5, 32'hFFFE0001, 4'd9, 1'b0);

    // Reset pulse while waiting on the ALU
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'd1; cmd_b = 16'd2; cmd_tag = 4'd3;
    tick();
    cmd_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    tick();
    r = 1'b1;
    tick();
    r = 1'b0;
    exp_cnt = 0; exp_s = '0; exp_x = '0; exp_y = '0;
    chk_reset_vals("rst_wait");
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    issue(4'd1, 16'd10, 16'd4, 4'd5);
    finish(0, 32'd6, 4'd5, 1'b0);

    // Reset beats a response handshake in the same cycle
    issue(4'd12, 16'h00F0, 16'h0FF0, 4'd11);
    rsp_ready = 1'b1;
    r = 1'b1;
    tick();
    r = 1'b0;
    rsp_ready = 1'b0;
    exp_cnt = 0; exp_s = '0; exp_x = '0; exp_y = '0;
    chk_reset_vals("rst_hs");

    for (int i = 0; i < 40; i++) rand_op($urandom_range(0, 3));

    guard = 0;
    while (exp_cnt != (1 << CNT_W) - 1 && guard < 400) begin
      rand_op(0);
      guard++;
    end
    chk("cnt_all_ones", 32'(op_cnt), 32'((1 << CNT_W) - 1));
    rand_op(1);
    chk("cnt_wrap", 32'(op_cnt), 32'd0);

    back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
